// File: rtl/remote_comm_link.sv
`default_nettype none
// ============================================================================
//  Module   : remote_comm_link
//  Purpose  : Host-side command link: sends a 16-bit command as two 8N1 UART
//             bytes (high byte first) and captures the robot's response byte.
//  Revision : 1.0
// ============================================================================
module remote_comm_link #(
    parameter int BAUD_DIV = 2604
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    output logic        TX,
    input  logic [15:0] cmd,
    input  logic        send_cmd,
    output logic        cmd_sent,
    output logic        resp_rdy,
    output logic [7:0]  resp
);

    localparam logic [11:0] c_BIT_END    = 12'(BAUD_DIV - 1);
    localparam logic [11:0] c_HALF_START = 12'(BAUD_DIV / 2 - 1);
    localparam logic [3:0]  c_LAST_BIT   = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SEND_HI = 2'd1,
        ST_SEND_LO = 2'd2
    } cmd_state_t;

    cmd_state_t  r_state;
    logic [7:0]  r_lo_byte;
    logic        r_cmd_sent;

    logic        r_tx;
    logic        r_tx_busy;
    logic        r_tx_done;
    logic [11:0] r_tx_cnt;
    logic [3:0]  r_tx_idx;
    logic [7:0]  r_tx_shift;

    logic        r_rx_meta;
    logic        r_rx_sync;
    logic        r_rx_prev;
    logic        r_rx_busy;
    logic [11:0] r_rx_cnt;
    logic [3:0]  r_rx_idx;
    logic [7:0]  r_rx_shift;
    logic [7:0]  r_resp;
    logic        r_resp_rdy;

    logic        w_accept;
    logic        w_tx_start;
    logic [7:0]  w_tx_byte;

    // The high byte goes straight from cmd so its start bit leaves one clock
    // after send_cmd; the low byte is replayed from the latched copy.
    assign w_accept   = (r_state == ST_IDLE) && send_cmd;
    assign w_tx_start = w_accept || ((r_state == ST_SEND_HI) && r_tx_done);
    assign w_tx_byte  = (r_state == ST_IDLE) ? cmd[15:8] : r_lo_byte;

    assign TX       = r_tx;
    assign cmd_sent = r_cmd_sent;
    assign resp_rdy = r_resp_rdy;
    assign resp     = r_resp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_lo_byte  <= 8'h00;
            r_cmd_sent <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (send_cmd) begin
                        r_lo_byte  <= cmd[7:0];
                        r_cmd_sent <= 1'b0;
                        r_state    <= ST_SEND_HI;
                    end
                end
                ST_SEND_HI: begin
                    if (r_tx_done) begin
                        r_state <= ST_SEND_LO;
                    end
                end
                ST_SEND_LO: begin
                    if (r_tx_done) begin
                        r_cmd_sent <= 1'b1;
                        r_state    <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Transmitter: bit index 0 is the start bit, 1..8 data, 9 the stop bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx       <= 1'b1;
            r_tx_busy  <= 1'b0;
            r_tx_done  <= 1'b0;
            r_tx_cnt   <= 12'd0;
            r_tx_idx   <= 4'd0;
            r_tx_shift <= 8'h00;
        end else begin
            r_tx_done <= 1'b0;
            if (!r_tx_busy) begin
                if (w_tx_start) begin
                    r_tx_busy  <= 1'b1;
                    r_tx       <= 1'b0;
                    r_tx_shift <= w_tx_byte;
                    r_tx_cnt   <= 12'd0;
                    r_tx_idx   <= 4'd0;
                end
            end else if (r_tx_cnt == c_BIT_END) begin
                r_tx_cnt <= 12'd0;
                if (r_tx_idx == c_LAST_BIT) begin
                    r_tx_busy <= 1'b0;
                    r_tx      <= 1'b1;
                    r_tx_done <= 1'b1;
                end else begin
                    r_tx_idx <= r_tx_idx + 4'd1;
                    if (r_tx_idx == 4'd8) begin
                        r_tx <= 1'b1;
                    end else begin
                        r_tx       <= r_tx_shift[0];
                        r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                    end
                end
            end else begin
                r_tx_cnt <= r_tx_cnt + 12'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= RX;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    // Receiver: sample 0 is mid start bit, 1..8 data, 9 the stop bit.
    // The set of resp_rdy is written last so it overrides any clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_busy  <= 1'b0;
            r_rx_cnt   <= 12'd0;
            r_rx_idx   <= 4'd0;
            r_rx_shift <= 8'h00;
            r_resp     <= 8'h00;
            r_resp_rdy <= 1'b0;
        end else begin
            if (w_accept) begin
                r_resp_rdy <= 1'b0;
            end
            if (!r_rx_busy) begin
                if (r_rx_prev && !r_rx_sync) begin
                    r_rx_busy  <= 1'b1;
                    r_rx_cnt   <= c_HALF_START;
                    r_rx_idx   <= 4'd0;
                    r_resp_rdy <= 1'b0;
                end
            end else if (r_rx_cnt == 12'd0) begin
                r_rx_cnt <= c_BIT_END;
                if (r_rx_idx == c_LAST_BIT) begin
                    r_rx_busy  <= 1'b0;
                    r_resp     <= r_rx_shift;
                    r_resp_rdy <= 1'b1;
                end else begin
                    r_rx_idx <= r_rx_idx + 4'd1;
                    if (r_rx_idx != 4'd0) begin
                        r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
                    end
                end
            end else begin
                r_rx_cnt <= r_rx_cnt - 12'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_remote_comm_link.sv
`default_nettype none
// ============================================================================
//  Module   : tb_remote_comm_link
//  Purpose  : Directed self-checking bench for remote_comm_link.
//  Revision : 1.0
// ============================================================================
module tb_remote_comm_link;

    localparam int B = 16;

    logic        clk;
    logic        rst_n;
    logic        rx_line;
    logic        rx_drv;
    logic        loop_en;
    logic        TX;
    logic [15:0] cmd;
    logic        send_cmd;
    logic        cmd_sent;
    logic        resp_rdy;
    logic [7:0]  resp;

    int n_checks = 0;
    int n_fail   = 0;

    assign rx_line = loop_en ? TX : rx_drv;

    remote_comm_link #(.BAUD_DIV(B)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .RX       (rx_line),
        .TX       (TX),
        .cmd      (cmd),
        .send_cmd (send_cmd),
        .cmd_sent (cmd_sent),
        .resp_rdy (resp_rdy),
        .resp     (resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Issue one command and check every TX bit mid-bit plus cmd_sent timing.
    // With glitch set, cmd is changed and send_cmd re-pulsed during both bytes.
    task automatic run_cmd(input logic [15:0] c, input bit glitch, input logic [15:0] gc);
        logic [9:0] fh;
        logic [9:0] fl;
        fh = {1'b1, c[15:8], 1'b0};
        fl = {1'b1, c[7:0], 1'b0};
        @(posedge clk); #1;
        cmd      = c;
        send_cmd = 1'b1;
        @(posedge clk); #1;
        send_cmd = 1'b0;
        check_eq("tx_start", {31'd0, TX}, 32'd0);
        check_eq("sent_drop", {31'd0, cmd_sent}, 32'd0);
        check_eq("rdy_drop", {31'd0, resp_rdy}, 32'd0);
        for (int t = 1; t <= 20 * B + 2; t++) begin
            @(posedge clk); #1;
            if (glitch) begin
                if (t == 2) cmd = gc;
                if (t == 5 * B || t == 15 * B) send_cmd = 1'b1;
                if (t == 5 * B + 1 || t == 15 * B + 1) send_cmd = 1'b0;
            end
            if (t < 10 * B && (t % B) == B / 2)
                check_eq("tx_hi_bit", {31'd0, TX}, {31'd0, fh[t / B]});
            if (t == 10 * B)
                check_eq("tx_gap", {31'd0, TX}, 32'd1);
            if (t == 10 * B + 1)
                check_eq("tx_lo_start", {31'd0, TX}, 32'd0);
            if (t > 10 * B && t <= 20 * B && ((t - 10 * B - 1) % B) == B / 2)
                check_eq("tx_lo_bit", {31'd0, TX}, {31'd0, fl[(t - 10 * B - 1) / B]});
            if (t == 20 * B + 1)
                check_eq("sent_early", {31'd0, cmd_sent}, 32'd0);
            if (t == 20 * B + 2)
                check_eq("sent_rise", {31'd0, cmd_sent}, 32'd1);
        end
        repeat (3 * B) @(posedge clk);
        #1;
        check_eq("tx_idle", {31'd0, TX}, 32'd1);
        check_eq("sent_hold", {31'd0, cmd_sent}, 32'd1);
    endtask

    // Remote robot sends one byte on RX; checks resp_rdy around the stop sample.
    task automatic remote_send(input logic [7:0] b);
        logic [9:0] f;
        f = {1'b1, b, 1'b0};
        repeat (3) @(posedge clk);
        for (int i = 0; i < 9; i++) begin
            #1 rx_drv = f[i];
            repeat (B) @(posedge clk);
        end
        #1 rx_drv = f[9];
        repeat (B / 2 + 1) @(posedge clk);
        #1;
        check_eq("rdy_before_stop", {31'd0, resp_rdy}, 32'd0);
        repeat (4) @(posedge clk);
        #1;
        check_eq("rdy_at_stop", {31'd0, resp_rdy}, 32'd1);
        check_eq("resp_echo", {24'd0, resp}, {24'd0, b});
    endtask

    initial begin
        rst_n    = 1'b0;
        cmd      = 16'h0000;
        send_cmd = 1'b0;
        rx_drv   = 1'b1;
        loop_en  = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_eq("rst_tx", {31'd0, TX}, 32'd1);
        check_eq("rst_sent", {31'd0, cmd_sent}, 32'd0);
        check_eq("rst_rdy", {31'd0, resp_rdy}, 32'd0);
        check_eq("rst_resp", {24'd0, resp}, 32'h00);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);

        run_cmd(16'h2A5C, 1'b0, 16'h0000);

        // Mid-transfer requests and cmd changes must not alter the frames
        run_cmd(16'h1234, 1'b1, 16'hFFFF);

        fork
            run_cmd(16'h0000, 1'b0, 16'h0000);
            remote_send(8'hA5);
        join
        check_eq("resp_kept", {24'd0, resp}, 32'hA5);
        check_eq("rdy_kept", {31'd0, resp_rdy}, 32'd1);

        run_cmd(16'h5C2A, 1'b0, 16'h0000);

        loop_en = 1'b1;
        run_cmd(16'h2A5C, 1'b0, 16'h0000);
        check_eq("loop_resp", {24'd0, resp}, 32'h5C);
        check_eq("loop_rdy", {31'd0, resp_rdy}, 32'd1);
        loop_en = 1'b0;

        // Reset while the low byte 0x3C is on the wire (bit 1 of frame is 0)
        @(posedge clk); #1;
        cmd      = 16'hA53C;
        send_cmd = 1'b1;
        @(posedge clk); #1;
        send_cmd = 1'b0;
        repeat (11 * B + B / 2 - 1) @(posedge clk);
        #3;
        check_eq("pre_rst_tx", {31'd0, TX}, 32'd0);
        #1 rst_n = 1'b0;
        #1;
        check_eq("mid_rst_tx", {31'd0, TX}, 32'd1);
        check_eq("mid_rst_sent", {31'd0, cmd_sent}, 32'd0);
        check_eq("mid_rst_resp", {24'd0, resp}, 32'h00);
        check_eq("mid_rst_rdy", {31'd0, resp_rdy}, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (12 * B) @(posedge clk);
        #1;
        check_eq("post_rst_tx", {31'd0, TX}, 32'd1);
        check_eq("post_rst_sent", {31'd0, cmd_sent}, 32'd0);

        run_cmd(16'hC33C, 1'b0, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
